// File: rtl/priority_resolver_isr.sv
// 8259-style priority resolver: ISR ownership, fully nested priority, INTA sequencing, vector output.
// Optional automatic rotation on non-specific EOI: define PRIORITY_ROTATE_EN.
module priority_resolver_isr #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] irr,
   input  logic [7:0] imr,
   input  logic [4:0] icw2_base,
   input  logic       inta_n,
   input  logic       eoi,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   output logic       int_req,
   output logic [7:0] isr,
   output logic [7:0] vector,
   output logic       vector_valid
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACK1 = 2'd1, ST_ACK2 = 2'd2} state_t;

   // Returns {found, level} of the highest-priority set bit; lp is the lowest-priority level.
   function automatic logic [3:0] top_level(input logic [7:0] bits, input logic [2:0] lp);
      logic [3:0] res;
      logic [2:0] lvl;
      res = 4'd0;
      for (int i = 8; i >= 1; i--) begin
         lvl = lp + 3'(i);
         if (bits[lvl]) res = {1'b1, lvl};
         else res = res;
      end
      return res;
   endfunction

   // Rank 0 is the highest priority.
   function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] lp);
      return lvl - lp - 3'd1;
   endfunction

   state_t                 state_r;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r, fall_r, rise_r;
   logic                   int_req_r, valid_r;
   logic [7:0]             isr_r, vector_r;
   logic [2:0]             sel_r;
   logic [2:0]             lp_s;
   logic [3:0]             cand_s, top_isr_s;
   logic                   pending_s;
   logic [7:0]             isr_clr_s, isr_set_s;

`ifdef PRIORITY_ROTATE_EN
   logic [2:0] lp_r;

   // Rotation pointer follows the level retired by each non-specific EOI.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lp_r <= 3'd7;
      else if (eoi && !eoi_specific && top_isr_s[3]) lp_r <= top_isr_s[2:0];
      else lp_r <= lp_r;
   end
   assign lp_s = lp_r;
`else
   assign lp_s = 3'd7;
`endif

   // INTA synchronizer with registered edge pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {SYNC_STAGES{1'b1}};
         prev_r <= 1'b1;
         fall_r <= 1'b0;
         rise_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], inta_n};
         prev_r <= sync_r[SYNC_STAGES-1];
         fall_r <= prev_r & ~sync_r[SYNC_STAGES-1];
         rise_r <= ~prev_r & sync_r[SYNC_STAGES-1];
      end
   end

   // Priority resolution and ISR set/clear masks.
   always_comb begin
      cand_s    = top_level(irr & ~imr, lp_s);
      top_isr_s = top_level(isr_r, lp_s);
      isr_clr_s = 8'd0;
      isr_set_s = 8'd0;
      if (cand_s[3] && (!top_isr_s[3] ||
          (rank_of(cand_s[2:0], lp_s) < rank_of(top_isr_s[2:0], lp_s)))) pending_s = 1'b1;
      else pending_s = 1'b0;
      if (eoi) begin
         if (eoi_specific) isr_clr_s[eoi_level] = 1'b1;
         else if (top_isr_s[3]) isr_clr_s[top_isr_s[2:0]] = 1'b1;
         else isr_clr_s = 8'd0;
      end else begin
         isr_clr_s = 8'd0;
      end
      if (state_r == ST_IDLE && fall_r && pending_s) isr_set_s[cand_s[2:0]] = 1'b1;
      else isr_set_s = 8'd0;
   end

   // Acknowledge FSM, ISR update and registered outputs; a set beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         int_req_r <= 1'b0;
         isr_r     <= 8'd0;
         vector_r  <= 8'd0;
         valid_r   <= 1'b0;
         sel_r     <= 3'd7;
      end else begin
         isr_r <= (isr_r & ~isr_clr_s) | isr_set_s;
         case (state_r)
            ST_IDLE: begin
               if (fall_r) begin
                  int_req_r <= 1'b0;
                  sel_r     <= pending_s ? cand_s[2:0] : 3'd7;
                  state_r   <= ST_ACK1;
               end else begin
                  int_req_r <= pending_s;
               end
            end
            ST_ACK1: begin
               int_req_r <= 1'b0;
               if (fall_r) begin
                  vector_r <= {icw2_base, sel_r};
                  valid_r  <= 1'b1;
                  state_r  <= ST_ACK2;
               end else begin
                  state_r <= ST_ACK1;
               end
            end
            ST_ACK2: begin
               int_req_r <= 1'b0;
               if (rise_r) begin
                  valid_r <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_ACK2;
               end
            end
            default: begin
               int_req_r <= 1'b0;
               valid_r   <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign int_req      = int_req_r;
   assign isr          = isr_r;
   assign vector       = vector_r;
   assign vector_valid = valid_r;

endmodule

// File: tb/tb_priority_resolver_isr.sv
// Self-checking bench for priority_resolver_isr: directed scenarios, then randomized traffic
// checked against an arithmetic priority model.
module tb_priority_resolver_isr;
   localparam int SYNC = 2;

   logic       clk, rst_n;
   logic [7:0] irr, imr;
   logic [4:0] icw2_base;
   logic       inta_n, eoi, eoi_specific;
   logic [2:0] eoi_level;
   logic       int_req, vector_valid;
   logic [7:0] isr, vector;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] m_isr;
   logic [7:0] m_vec;
   int         m_lp;

   priority_resolver_isr #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .icw2_base(icw2_base),
      .inta_n(inta_n), .eoi(eoi), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
      .int_req(int_req), .isr(isr), .vector(vector), .vector_valid(vector_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic inta_level(input logic lvl);
      inta_n = lvl;
      settle(SYNC + 4);
   endtask

   task automatic strobe_eoi(input logic spec, input logic [2:0] lvl);
      eoi = 1'b1; eoi_specific = spec; eoi_level = lvl;
      settle(1);
      eoi = 1'b0;
      settle(2);
   endtask

   // Model: priority rank 0 is highest; highest level is m_lp+1 mod 8.
   function automatic int mrank(input int lvl);
      return (lvl - m_lp - 1 + 16) % 8;
   endfunction

   function automatic int mtop(input logic [7:0] b);
      int best = -1;
      for (int l = 0; l < 8; l++)
         if (b[l] && (best < 0 || mrank(l) < mrank(best))) best = l;
      return best;
   endfunction

   function automatic bit mpend();
      int c = mtop(irr & ~imr);
      int t = mtop(m_isr);
      return (c >= 0) && (t < 0 || mrank(c) < mrank(t));
   endfunction

   task automatic model_ack(input bit perturb);
      int sel;
      inta_n = 1'b0;
      settle(SYNC + 4);
      if (mpend()) begin
         sel = mtop(irr & ~imr);
         m_isr[sel] = 1'b1;
      end else begin
         sel = 7;
      end
      check("r_isr_ack1", isr, m_isr);
      check("r_intreq_ack1", int_req, 0);
      if (perturb) begin
         irr = 8'($urandom);
         imr = 8'($urandom);
      end
      inta_level(1'b1);
      inta_level(1'b0);
      m_vec = {icw2_base, 3'(sel)};
      check("r_vector", vector, m_vec);
      check("r_valid_hi", vector_valid, 1);
      inta_level(1'b1);
      check("r_valid_lo", vector_valid, 0);
      check("r_vector_hold", vector, m_vec);
   endtask

   task automatic model_eoi(input bit spec, input int lvl);
      int t = mtop(m_isr);
      strobe_eoi(spec, 3'(lvl));
      if (spec) m_isr[lvl] = 1'b0;
      else if (t >= 0) begin
         m_isr[t] = 1'b0;
`ifdef PRIORITY_ROTATE_EN
         m_lp = t;
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0; irr = 8'h00; imr = 8'h00; icw2_base = 5'h01;
      inta_n = 1'b1; eoi = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
      settle(3);
      check("rst_int_req", int_req, 0);
      check("rst_isr", isr, 8'h00);
      check("rst_vector", vector, 8'h00);
      check("rst_valid", vector_valid, 0);
      rst_n = 1'b1;
      settle(2);

      // Basic acknowledge of IR2 out of {IR2, IR5}.
      irr = 8'h24;
      settle(1);
      check("int_req_latency", int_req, 1);
      inta_n = 1'b0;
      settle(SYNC + 1);
      check("isr_before_edge", isr, 8'h00);
      settle(1);
      check("isr_after_ack1", isr, 8'h04);
      check("int_req_drop", int_req, 0);
      settle(2);
      inta_level(1'b1);
      check("valid_between", vector_valid, 0);
      inta_level(1'b0);
      check("vector_ir2", vector, 8'h0A);
      check("valid_ir2", vector_valid, 1);
      inta_level(1'b1);
      check("valid_release", vector_valid, 0);
      check("vector_retained", vector, 8'h0A);

      // Nesting: IR5 blocked by IR2 in service, IR0 preempts.
      irr = 8'h20;
      settle(3);
      check("nest_blocked", int_req, 0);
      irr = 8'h21;
      settle(2);
      check("nest_preempt", int_req, 1);
      inta_level(1'b0); inta_level(1'b1); inta_level(1'b0);
      check("nest_isr", isr, 8'h05);
      check("nest_vector", vector, 8'h08);
      inta_level(1'b1);
      irr = 8'h00;

      // EOI forms.
      strobe_eoi(1'b0, 3'd0);
      check("eoi_nonspec", isr, 8'h04);
      strobe_eoi(1'b1, 3'd2);
      check("eoi_spec", isr, 8'h00);
      strobe_eoi(1'b1, 3'd5);
      check("eoi_spec_clear", isr, 8'h00);

      // Masked request and spurious acknowledge.
      irr = 8'h08; imr = 8'h08;
      settle(3);
      check("masked_no_req", int_req, 0);
      inta_level(1'b0);
      check("spur_isr", isr, 8'h00);
      inta_level(1'b1); inta_level(1'b0);
      check("spur_vector", vector, 8'h0F);
      inta_level(1'b1);

      // Rotation: service IR0, non-specific EOI, then IR0 and IR1 together.
      imr = 8'h00; irr = 8'h01;
      settle(2);
      inta_level(1'b0); inta_level(1'b1); inta_level(1'b0); inta_level(1'b1);
      check("rot_isr0", isr, 8'h01);
      irr = 8'h00;
      strobe_eoi(1'b0, 3'd0);
      irr = 8'h03;
      settle(2);
      inta_level(1'b0); inta_level(1'b1); inta_level(1'b0);
`ifdef PRIORITY_ROTATE_EN
      check("rot_grant", vector, 8'h09);
`else
      check("rot_grant", vector, 8'h08);
`endif
      inta_level(1'b1);

      // Reset in ACK1, then a clean sequence.
      strobe_eoi(1'b1, 3'd0);
      strobe_eoi(1'b1, 3'd1);
      irr = 8'h01;
      settle(2);
      inta_level(1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_int_req", int_req, 0);
      check("arst_isr", isr, 8'h00);
      check("arst_vector", vector, 8'h00);
      check("arst_valid", vector_valid, 0);
      inta_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      irr = 8'h10;
      settle(2);
      check("post_rst_req", int_req, 1);
      inta_level(1'b0); inta_level(1'b1); inta_level(1'b0);
      check("post_rst_isr", isr, 8'h10);
      check("post_rst_vector", vector, 8'h0C);
      check("post_rst_valid", vector_valid, 1);
      inta_level(1'b1);

      // Randomized traffic against the model, from a fresh reset.
      rst_n = 1'b0; irr = 8'h00;
      settle(2);
      rst_n = 1'b1;
      m_isr = 8'h00; m_vec = 8'h00; m_lp = 7;
      settle(1);
      for (int it = 0; it < 60; it++) begin
         irr = 8'($urandom);
         imr = 8'($urandom) & 8'($urandom);
         icw2_base = 5'($urandom);
         settle(3);
         check("r_int_req", int_req, mpend());
         case ($urandom_range(0, 2))
            0: model_ack(1'b0);
            1: model_ack(1'b1);
            default: begin
               model_eoi(bit'($urandom_range(0, 1)), $urandom_range(0, 7));
               check("r_isr_eoi", isr, m_isr);
            end
         endcase
         settle(2);
         check("r_int_req_post", int_req, mpend());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
